collision_detector: RTL and testbench

Upstream neighbour of the score display: it tracks the snake body and turns each head move into one goodCollButton/badCollButton-style pulse for the scorer.
- Owns the body segment array.
- Checks each new head position against the grid walls, the body and the apple.
- Emits one single-cycle goodColl or badColl pulse per move, then updates the body.
- Body is checked serially, one segment per cycle.

---
 rtl/collision_detector.sv | 106 ++++++++++
 tb/tb_collision_detector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// collision_detector: owns the snake body and turns each head move into one good/bad collision pulse
module collision_detector #(
    parameter int COORD_W  = 4,
    parameter int GRID_W   = 14,
    parameter int GRID_H   = 10,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 8,
    parameter int START_Y  = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [COORD_W-1:0]           head_x,
    input  logic [COORD_W-1:0]           head_y,
    input  logic [COORD_W-1:0]           apple_x,
    input  logic [COORD_W-1:0]           apple_y,
    output logic                         goodColl,
    output logic                         badColl,
    output logic                         done,
    output logic                         busy,
    output logic [COORD_W-1:0]           cur_x,
    output logic [COORD_W-1:0]           cur_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, REPORT} state_t;

    state_t              state, state_n;
    logic [COORD_W-1:0]  seg_x [MAX_LEN];
    logic [COORD_W-1:0]  seg_y [MAX_LEN];
    logic [COORD_W-1:0]  hx, hy;
    logic [IW-1:0]       idx;
    logic                wall_q, apple_q, self_q, good_q, bad_q;
    logic                bad, good, last;

    always_comb begin
        bad = wall_q | self_q;
        good = apple_q & ~bad;
        last = LW'(idx) == length - LW'(2);
        state_n = state == IDLE   ? (step ? (length > 1 ? SCAN : UPDATE) : IDLE) :
                  state == SCAN   ? (last ? UPDATE : SCAN) :
                  state == UPDATE ? REPORT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            length <= LW'(INIT_LEN);
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= COORD_W'(START_X - i);
                seg_y[i] <= COORD_W'(START_Y);
            end
            hx <= '0;
            hy <= '0;
            idx <= '0;
            wall_q <= 1'b0;
            apple_q <= 1'b0;
            self_q <= 1'b0;
            good_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (step) begin
                    hx <= head_x;
                    hy <= head_y;
                    wall_q <= 32'(head_x) >= GRID_W || 32'(head_y) >= GRID_H;
                    apple_q <= head_x == apple_x && head_y == apple_y;
                    self_q <= 1'b0;
                    idx <= '0;
                end
                // the tail is never visited: it vacates the cell during this move
                SCAN: begin
                    self_q <= self_q | (hx == seg_x[idx] && hy == seg_y[idx]);
                    idx <= idx + 1'b1;
                end
                UPDATE: begin
                    bad_q <= bad;
                    good_q <= good;
                    if (bad) begin
                        if (length > 1) length <= length - 1'b1;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= hx;
                        seg_y[0] <= hy;
                        if (good && length != LW'(MAX_LEN)) length <= length + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = state != IDLE;
    assign done = state == REPORT;
    assign goodColl = done & good_q;
    assign badColl = done & bad_q;
    assign cur_x = seg_x[0];
    assign cur_y = seg_y[0];
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: queue-based body model checked every cycle, plus directed literal checks
module tb_collision_detector;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic [3:0] head_x = '0, head_y = '0, apple_x = '0, apple_y = '0;
    logic       goodColl, badColl, done, busy;
    logic [3:0] cur_x, cur_y;
    logic [4:0] length;

    collision_detector dut (
        .clk(clk), .rst(rst), .step(step),
        .head_x(head_x), .head_y(head_y), .apple_x(apple_x), .apple_y(apple_y),
        .goodColl(goodColl), .badColl(badColl), .done(done), .busy(busy),
        .cur_x(cur_x), .cur_y(cur_y), .length(length)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, passed = 0;
    int n_done = 0, n_good = 0, n_bad = 0, last_done = -1;

    // model: body as a queue, head at index 0; expectations switch to the new body at the report cycle
    int bx[$], by[$];
    int o_x, o_y, o_len, step_cyc, rep_cyc;
    bit m_good, m_bad;

    task automatic check(string n, int got, int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", n, got, exp, cyc);
    endtask

    task automatic model_reset();
        bx = {8, 7, 6};
        by = {6, 6, 6};
        step_cyc = -1;
        rep_cyc = -1;
        m_good = 0;
        m_bad = 0;
    endtask

    task automatic model_step(int hx, int hy, int ax, int ay);
        bit self_hit = 0;
        int len = bx.size();
        if (cyc > step_cyc && cyc <= rep_cyc) return;
        for (int i = 0; i < len - 1; i++)
            if (bx[i] == hx && by[i] == hy) self_hit = 1;
        m_bad = hx >= 14 || hy >= 10 || self_hit;
        m_good = hx == ax && hy == ay && !m_bad;
        o_x = bx[0];
        o_y = by[0];
        o_len = len;
        if (m_bad) begin
            if (len > 1) begin void'(bx.pop_back()); void'(by.pop_back()); end
        end else begin
            bx.push_front(hx);
            by.push_front(hy);
            if (!m_good || bx.size() > 16) begin void'(bx.pop_back()); void'(by.pop_back()); end
        end
        step_cyc = cyc;
        rep_cyc = cyc + len + 1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            bit ed;
            bit after;
            ed = cyc == rep_cyc;
            after = cyc >= rep_cyc;
            check("busy", busy, cyc > step_cyc && cyc <= rep_cyc);
            check("done", done, ed);
            check("goodColl", goodColl, ed && m_good);
            check("badColl", badColl, ed && m_bad);
            check("cur_x", cur_x, after ? bx[0] : o_x);
            check("cur_y", cur_y, after ? by[0] : o_y);
            check("length", length, after ? bx.size() : o_len);
            if (done) begin n_done++; last_done = cyc; end
            if (goodColl) n_good++;
            if (badColl) n_bad++;
        end
    end

    task automatic do_reset(int n);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (n) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic step_in(int hx, int hy, int ax, int ay, output int t);
        @(negedge clk);
        head_x = 4'(hx); head_y = 4'(hy); apple_x = 4'(ax); apple_y = 4'(ay);
        step = 1'b1;
        t = cyc;
        model_step(hx, hy, ax, ay);
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc <= rep_cyc) @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic move(int hx, int hy, int ax, int ay, output int t);
        step_in(hx, hy, ax, ay, t);
        wait_idle();
    endtask

    int t, t2, d0, g0, b0;
    int sx[14] = '{8, 8, 8, 8, 8, 8, 9, 10, 11, 12, 13, 13, 13, 13};
    int sy[14] = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 1, 2, 3};

    initial begin
        model_reset();
        do_reset(2);
        check("rst_cur_x", cur_x, 8);
        check("rst_cur_y", cur_y, 6);
        check("rst_len", length, 3);
        check("rst_busy", busy, 0);

        move(9, 6, 3, 3, t);
        check("plain_lat", last_done, t + 4);
        check("plain_cnt", n_done, 1);
        check("plain_cur_x", cur_x, 9);
        check("plain_len", length, 3);

        move(10, 6, 10, 6, t);
        check("eat_lat", last_done, t + 4);
        check("eat_good", n_good, 1);
        check("eat_len", length, 4);
        move(11, 6, 0, 0, t);
        check("len4_lat", last_done, t + 5);
        check("len4_cur_x", cur_x, 11);

        do_reset(2);
        b0 = n_bad;
        move(14, 6, 0, 0, t);
        check("wall_lat", last_done, t + 4);
        check("wall_bad", n_bad - b0, 1);
        check("wall_cur_x", cur_x, 8);
        check("wall_len", length, 2);
        move(3, 10, 0, 0, t);
        check("wall2_lat", last_done, t + 3);
        check("wall2_len", length, 1);
        move(15, 15, 15, 15, t);
        check("wall3_lat", last_done, t + 2);
        check("wall3_len", length, 1);
        check("wall3_bad", n_bad - b0, 3);

        do_reset(2);
        b0 = n_bad;
        move(7, 6, 7, 6, t);
        check("self_bad", n_bad - b0, 1);
        check("self_len", length, 2);
        check("self_cur_x", cur_x, 8);
        do_reset(2);
        b0 = n_bad;
        g0 = n_good;
        move(6, 6, 0, 0, t);
        check("tail_nobad", n_bad - b0, 0);
        check("tail_nogood", n_good - g0, 0);
        check("tail_cur_x", cur_x, 6);
        check("tail_len", length, 3);

        do_reset(2);
        d0 = n_done;
        step_in(9, 6, 0, 0, t);
        step_in(9, 7, 0, 0, t2);
        check("ign_when", t2, t + 2);
        wait_idle();
        check("ign_done", n_done - d0, 1);
        check("ign_cur_y", cur_y, 6);

        do_reset(2);
        d0 = n_done;
        step_in(9, 6, 9, 6, t);
        do_reset(1);
        check("mid_busy", busy, 0);
        repeat (6) @(negedge clk);
        #1;
        check("mid_done", n_done - d0, 0);
        check("mid_len", length, 3);
        check("mid_cur_x", cur_x, 8);

        do_reset(2);
        g0 = n_good;
        for (int i = 0; i < 13; i++) move(sx[i], sy[i], sx[i], sy[i], t);
        check("sat_len13", length, 16);
        move(sx[13], sy[13], sx[13], sy[13], t);
        check("sat_lat", last_done, t + 17);
        check("sat_good", n_good - g0, 14);
        check("sat_len14", length, 16);
        check("sat_cur_x", cur_x, 13);
        check("sat_cur_y", cur_y, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
